// File: rtl/wb_dbg_master.sv
// Byte-stream debug master: UART command frames drive single 32-bit Wishbone B4 pipelined accesses.
// Latency: last command byte -> cyc 1 cycle; ACK/ERR -> tx_valid_o 1 cycle.
// Backpressure: tx bytes held until tx_ready_i; rx bytes arriving while busy on the bus are dropped and flag overrun.
module wb_dbg_master #(
    parameter int BUS_TIMEOUT = 256,
    parameter int RX_TIMEOUT  = 65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i,
    output logic        busy_o,
    output logic        overrun_o
);
    localparam int TMAX  = (BUS_TIMEOUT > RX_TIMEOUT) ? BUS_TIMEOUT : RX_TIMEOUT;
    localparam int CNT_W = $clog2(TMAX + 1);

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] ST_OK = 8'h4B;
    localparam logic [7:0] ST_ER = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS_REQ, S_BUS_WAIT, S_RESP, S_RDATA
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmr;
    logic [1:0]       byte_cnt;
    logic             we_r;
    logic [31:0]      adr_r, dat_r, rdata_r;
    logic [7:0]       status_r;
    logic             ovr_r;

    logic rx_opcode, rx_accept, bus_resp, bus_tmo, rx_tmo, bus_phase;

    always_comb begin
        rx_opcode = (rx_data_i == OP_W) || (rx_data_i == OP_R);
        rx_accept = rx_valid_i && ((state == S_ADDR) || (state == S_DATA));
        bus_phase = (state == S_BUS_REQ) || (state == S_BUS_WAIT);
        // A response is only meaningful once STB has been (or is being) accepted.
        bus_resp  = (wbm_ack_i || wbm_err_i) &&
                    ((state == S_BUS_WAIT) || ((state == S_BUS_REQ) && !wbm_stall_i));
        bus_tmo   = (tmr == CNT_W'(BUS_TIMEOUT - 1));
        rx_tmo    = (tmr == CNT_W'(RX_TIMEOUT - 1));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        case (state)
            S_IDLE: begin
                if (rx_valid_i && rx_opcode) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (rx_valid_i && (byte_cnt == 2'd3)) state_nxt = we_r ? S_DATA : S_BUS_REQ;
                else if (!rx_valid_i && rx_tmo)       state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (rx_valid_i && (byte_cnt == 2'd3)) state_nxt = S_BUS_REQ;
                else if (!rx_valid_i && rx_tmo)       state_nxt = S_IDLE;
            end
            S_BUS_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (bus_resp || bus_tmo) state_nxt = S_RESP;
                else if (!wbm_stall_i)   state_nxt = S_BUS_WAIT;
            end
            S_BUS_WAIT: begin
                wbm_cyc_o = 1'b1;
                if (bus_resp || bus_tmo) state_nxt = S_RESP;
            end
            S_RESP: begin
                tx_valid_o = 1'b1;
                tx_data_o  = status_r;
                if (tx_ready_i) state_nxt = (!we_r && (status_r == ST_OK)) ? S_RDATA : S_IDLE;
            end
            S_RDATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = rdata_r[31:24];
                if (tx_ready_i && (byte_cnt == 2'd3)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmr      <= '0;
            byte_cnt <= 2'd0;
            we_r     <= 1'b0;
            adr_r    <= 32'h0;
            dat_r    <= 32'h0;
            rdata_r  <= 32'h0;
            status_r <= 8'h00;
            ovr_r    <= 1'b0;
        end else begin
            // Bus timer spans BUS_REQ and BUS_WAIT, so the REQ->WAIT step must not restart it.
            if (((state_nxt != state) && (state_nxt != S_BUS_WAIT)) || rx_accept)
                tmr <= '0;
            else
                tmr <= tmr + CNT_W'(1);

            if (rx_valid_i && (bus_phase || (state == S_RESP) || (state == S_RDATA)))
                ovr_r <= 1'b1;
            else if (rx_valid_i && (state == S_IDLE) && rx_opcode)
                ovr_r <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_valid_i && rx_opcode) begin
                        we_r     <= (rx_data_i == OP_W);
                        byte_cnt <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        adr_r    <= {adr_r[23:0], rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        dat_r    <= {dat_r[23:0], rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_BUS_REQ, S_BUS_WAIT: begin
                    if (bus_resp) begin
                        status_r <= wbm_err_i ? ST_ER : ST_OK;
                        if (!wbm_err_i && !we_r) rdata_r <= wbm_dat_i;
                    end else if (bus_tmo) begin
                        status_r <= ST_ER;
                    end
                end
                S_RDATA: begin
                    if (tx_ready_i) begin
                        rdata_r  <= {rdata_r[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm_we_o  = we_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign wbm_sel_o = 4'hF;
    assign busy_o    = (state != S_IDLE);
    assign overrun_o = ovr_r;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Bench for wb_dbg_master: directed vector table plus randomized frames against a response model.
module tb_wb_dbg_master;
    localparam int BUS_TIMEOUT = 16;
    localparam int RX_TIMEOUT  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0, err = 1'b0, stall = 1'b0;
    logic        busy, overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_dbg_master #(.BUS_TIMEOUT(BUS_TIMEOUT), .RX_TIMEOUT(RX_TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_stall_i(stall),
        .busy_o(busy), .overrun_o(overrun)
    );

    // mode: 0 = ACK, 1 = ERR, 2 = silent slave, 3 = ACK and ERR together
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          stall;
        int          lat;
        int          mode;
        logic [31:0] rdata;
        int          hold;
        bit          inject;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t      vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: status byte from the slave outcome, then read data big-endian on a good read.
    function automatic void build_exp(input vec_t v);
        exp_q.delete();
        if (v.mode == 0) begin
            exp_q.push_back(8'h4B);
            if (!v.we)
                for (int i = 3; i >= 0; i--) exp_q.push_back(v.rdata[i*8 +: 8]);
        end else begin
            exp_q.push_back(8'h45);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic service(input vec_t v);
        int n;
        chk("cyc_latency", {31'b0, cyc}, 32'd1);
        if (v.mode == 2) begin
            n = 0;
            while (cyc && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_cycles", n, BUS_TIMEOUT);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("late_ack_cyc", {31'b0, cyc}, 32'd0);
            return;
        end
        stall = 1'b1;
        for (int i = 0; i < v.stall; i++) @(negedge clk);
        chk("stb_held", {31'b0, stb}, 32'd1);
        stall = 1'b0;
        chk("bus_adr", adr, v.adr);
        chk("bus_we", {31'b0, we}, {31'b0, v.we});
        chk("bus_sel", {28'b0, sel}, 32'hF);
        if (v.we) chk("bus_dat", dat_o, v.dat);
        dat_i = v.rdata;
        if (v.lat == 0) begin
            ack = (v.mode == 0) || (v.mode == 3);
            err = (v.mode == 1) || (v.mode == 3);
        end
        @(negedge clk);
        if (v.lat > 0) begin
            chk("stb_drop", {30'b0, cyc, stb}, 32'd2);
            for (int i = 0; i < v.lat - 1; i++) @(negedge clk);
            ack = (v.mode == 0) || (v.mode == 3);
            err = (v.mode == 1) || (v.mode == 3);
            @(negedge clk);
        end
        ack   = 1'b0;
        err   = 1'b0;
        dat_i = $urandom;
        chk("cyc_after_resp", {31'b0, cyc}, 32'd0);
        chk("tx_latency", {31'b0, tx_valid}, 32'd1);
    endtask

    task automatic collect(input vec_t v);
        int   idx;
        bit   done, prev_stalled, r;
        logic [7:0] prev_dat;
        got_q.delete();
        idx = 0; done = 0; prev_stalled = 0; prev_dat = 8'h00;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            if (prev_stalled) chk("tx_stable", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, prev_dat});
            r = (idx == 0) ? 1'b1 : (idx <= v.hold) ? 1'b0 : 1'($urandom_range(0, 1));
            tx_ready = r;
            rx_valid = v.inject && (idx == 3);
            rx_data  = 8'h00;
            if (tx_valid && r) got_q.push_back(tx_data);
            prev_stalled = tx_valid && !r;
            prev_dat     = tx_data;
            idx++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        if (!done) chk("tx_drain_bound", 32'd0, 32'd1);
    endtask

    task automatic run(input vec_t v);
        send_byte(v.we ? 8'h57 : 8'h52);
        chk("overrun_clear", {31'b0, overrun}, 32'd0);
        for (int i = 3; i >= 0; i--) send_byte(v.adr[i*8 +: 8]);
        if (v.we) for (int i = 3; i >= 0; i--) send_byte(v.dat[i*8 +: 8]);
        service(v);
        collect(v);
        build_exp(v);
        chk("tx_len", got_q.size(), exp_q.size());
        if (got_q.size() > 0) chk("tx_status", {24'b0, got_q[0]}, {24'b0, v.exp_status});
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("tx_byte", {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        chk("overrun", {31'b0, overrun}, {31'b0, v.inject});
    endtask

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input int s, input int l, input int m, input logic [31:0] rd,
                                input int h, input bit inj);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.stall = s; v.lat = l; v.mode = m;
        v.rdata = rd; v.hold = h; v.inject = inj;
        v.exp_status = (m == 0) ? 8'h4B : 8'h45;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   m;
        bit   seen;

        vecs.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 32'h0100_0004, 32'h0, 3, 1, 0, 32'h1234_5678, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0020, 32'h0, 0, 2, 1, 32'hAAAA_5555, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0030, 32'h0, 0, 0, 2, 32'h0, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0041, 32'h0, 0, 1, 0, 32'hCAFE_F00D, 10, 1));
        vecs.push_back(mk(0, 32'h0000_0050, 32'h0, 1, 1, 3, 32'h1111_2222, 0, 0));
        vecs.push_back(mk(0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 32'h8765_4321, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0003, 32'h0102_0304, 2, 0, 1, 32'h0, 0, 0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cyc", {31'b0, cyc}, 32'd0);
        chk("rst_stb", {31'b0, stb}, 32'd0);
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_sel", {28'b0, sel}, 32'hF);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);

        foreach (vecs[i]) run(vecs[i]);

        // Partial frame abandoned by the receive timeout, then a clean frame.
        send_byte(8'h52);
        send_byte(8'h00);
        seen = 0;
        for (int i = 0; i < RX_TIMEOUT - 5; i++) begin
            seen |= tx_valid;
            @(negedge clk);
        end
        chk("rx_tmo_still_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            seen |= tx_valid;
            @(negedge clk);
        end
        chk("rx_tmo_idle", {31'b0, busy}, 32'd0);
        chk("rx_tmo_no_tx", {31'b0, seen}, 32'd0);
        run(mk(0, 32'h0000_0100, 32'h0, 0, 1, 0, 32'h0BAD_CAFE, 0, 0));

        // Reset in the middle of a bus access drops the frame silently.
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cyc_stb", {30'b0, cyc, stb}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen |= tx_valid | cyc;
            @(negedge clk);
        end
        chk("midrst_quiet", {31'b0, seen}, 32'd0);

        for (int n = 0; n < 25; n++) begin
            m = $urandom_range(0, 9);
            v = mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 4),
                   (m < 6) ? 0 : (m < 8) ? 1 : (m < 9) ? 2 : 3,
                   $urandom, $urandom_range(0, 4), 1'b0);
            if (v.mode == 0 && !v.we && v.hold >= 3) v.inject = 1'($urandom_range(0, 1));
            run(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
